// File: rtl/ram_port_arbiter_pkg.sv
// Shared definitions for the RAM port arbiter: FSM encoding and requester indices.
package ram_port_arbiter_pkg;

  // Width of the grant index; covers up to four requesters.
  localparam int unsigned GrantW = 2;

  // Requester slots on the shared RAM port.
  localparam int unsigned ReqDma    = 0;
  localparam int unsigned ReqStack  = 1;
  localparam int unsigned ReqIfetch = 2;

  typedef enum logic [1:0] {
    ArbIdle  = 2'd0,
    ArbIssue = 2'd1,
    ArbWait  = 2'd2,
    ArbDone  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester and RAM-side bundle of the shared RAM port arbiter.
interface ram_port_arbiter_if #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        ack;
  logic [DATA_W-1:0]         rdata;
  logic                      busy;
  logic [1:0]                last_grant;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_wdata;
  logic                      mem_we;
  logic [DATA_W-1:0]         mem_rdata;

  // Arbiter side.
  modport slave (
    input  req, req_we, req_addr, req_wdata, mem_rdata,
    output ack, rdata, busy, last_grant, mem_addr, mem_wdata, mem_we
  );

  // Requesters plus RAM side.
  modport master (
    output req, req_we, req_addr, req_wdata, mem_rdata,
    input  ack, rdata, busy, last_grant, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/ram_port_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request after last_i, wrapping.
module ram_port_arbiter_rr_pick
  import ram_port_arbiter_pkg::*;
#(
  parameter int unsigned NumReq = 3
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [GrantW-1:0] last_i,
  output logic [GrantW-1:0] winner_o,
  output logic              valid_o
);

  logic [2*NumReq-1:0] rot;
  int unsigned         w;

  // Rotate so bit 0 is the slot right after the last winner, then take the lowest set bit.
  always_comb begin
    rot      = {req_i, req_i} >> ({1'b0, last_i} + 3'd1);
    winner_o = '0;
    valid_o  = 1'b0;
    w        = 0;
    for (int i = 0; i < NumReq; i++) begin
      if (!valid_o && rot[i]) begin
        w = 32'(last_i) + 1 + 32'(i);
        if (w >= NumReq) w = w - NumReq;
        if (w >= NumReq) w = w - NumReq;
        winner_o = GrantW'(w);
        valid_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing the DMA-side data RAM port between requesters.
// One registered transaction at a time; reads wait out the RAM latency before ack.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 3,
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned READ_LATENCY = 1
) (
  input logic                physical_clock,
  input logic                n_reset,
  ram_port_arbiter_if.slave  bus_io
);

  localparam logic [1:0]        WaitInit = 2'(READ_LATENCY - 1);
  localparam logic [GrantW-1:0] LastInit = GrantW'(NUM_REQ - 1);

  arb_state_e        state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [GrantW-1:0] last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [GrantW-1:0] winner;
  logic              win_valid;
  logic [ADDR_W-1:0] addr_arr  [NUM_REQ];
  logic [DATA_W-1:0] wdata_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign addr_arr[g]  = bus_io.req_addr[g*ADDR_W +: ADDR_W];
    assign wdata_arr[g] = bus_io.req_wdata[g*DATA_W +: DATA_W];
  end

  ram_port_arbiter_rr_pick #(
    .NumReq (NUM_REQ)
  ) u_rr_pick (
    .req_i    (bus_io.req),
    .last_i   (last_grant_q),
    .winner_o (winner),
    .valid_o  (win_valid)
  );

  // State and datapath registers; reset abandons any transaction in flight.
  always_ff @(posedge physical_clock or negedge n_reset) begin
    if (!n_reset) begin
      state_q      <= ArbIdle;
      cnt_q        <= '0;
      last_grant_q <= LastInit;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
      rdata_q      <= rdata_d;
    end
  end

  // Next-state: grant in IDLE, writes finish after ISSUE, reads count down in WAIT.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_we_d     = mem_we_q;
    rdata_d      = rdata_q;
    unique case (state_q)
      ArbIdle: begin
        mem_we_d = 1'b0;
        if (win_valid) begin
          state_d      = ArbIssue;
          last_grant_d = winner;
          mem_addr_d   = addr_arr[winner];
          mem_wdata_d  = wdata_arr[winner];
          mem_we_d     = bus_io.req_we[winner];
        end
      end
      ArbIssue: begin
        if (mem_we_q) begin
          mem_we_d = 1'b0;
          state_d  = ArbDone;
        end else begin
          cnt_d   = WaitInit;
          state_d = ArbWait;
        end
      end
      ArbWait: begin
        if (cnt_q == 2'd0) begin
          // RAM data is valid on this edge; it is presented alongside the ack.
          rdata_d = bus_io.mem_rdata;
          state_d = ArbDone;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      ArbDone: state_d = ArbIdle;
      default: state_d = ArbIdle;
    endcase
  end

  // Outputs: ack pulses for the DONE cycle only, busy covers the RAM access.
  always_comb begin
    bus_io.ack = '0;
    if (state_q == ArbDone) bus_io.ack[last_grant_q] = 1'b1;
    bus_io.busy       = (state_q == ArbIssue) || (state_q == ArbWait);
    bus_io.last_grant = last_grant_q;
    bus_io.rdata      = rdata_q;
    bus_io.mem_addr   = mem_addr_q;
    bus_io.mem_wdata  = mem_wdata_q;
    bus_io.mem_we     = mem_we_q;
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a scoreboard of expected acks.
module tb_ram_port_arbiter;
  import ram_port_arbiter_pkg::*;

  localparam int unsigned NR = 3;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1_n = 1'b1;
  logic rst3_n = 1'b1;

  ram_port_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus1 ();
  ram_port_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus3 ();

  ram_port_arbiter #(
    .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(1)
  ) dut1 (
    .physical_clock (clk),
    .n_reset        (rst1_n),
    .bus_io         (bus1)
  );

  ram_port_arbiter #(
    .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(3)
  ) dut3 (
    .physical_clock (clk),
    .n_reset        (rst3_n),
    .bus_io         (bus3)
  );

  // Requester-side drive state, flattened onto the interfaces.
  logic [NR-1:0] rq1 = '0, wq1 = '0, rq3 = '0, wq3 = '0;
  logic [AW-1:0] a1 [NR];
  logic [DW-1:0] d1 [NR];
  logic [AW-1:0] a3 [NR];
  logic [DW-1:0] d3 [NR];
  assign bus1.req       = rq1;
  assign bus1.req_we    = wq1;
  assign bus1.req_addr  = {a1[2], a1[1], a1[0]};
  assign bus1.req_wdata = {d1[2], d1[1], d1[0]};
  assign bus3.req       = rq3;
  assign bus3.req_we    = wq3;
  assign bus3.req_addr  = {a3[2], a3[1], a3[0]};
  assign bus3.req_wdata = {d3[2], d3[1], d3[0]};

  // RAM models: data valid READ_LATENCY cycles after the address is registered.
  logic [DW-1:0] ram1 [65536];
  logic [DW-1:0] ram3 [65536];
  logic [DW-1:0] p1 = '0, p3a = '0, p3b = '0, p3c = '0;
  always @(posedge clk) begin
    if (bus1.mem_we) ram1[bus1.mem_addr] <= bus1.mem_wdata;
    p1 <= ram1[bus1.mem_addr];
    if (bus3.mem_we) ram3[bus3.mem_addr] <= bus3.mem_wdata;
    p3a <= ram3[bus3.mem_addr];
    p3b <= p3a;
    p3c <= p3b;
  end
  assign bus1.mem_rdata = p1;
  assign bus3.mem_rdata = p3c;

  typedef struct packed {
    logic [NR-1:0] ack;
    logic          rd;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb1[$];
  exp_t sb3[$];
  exp_t e1, e3;
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int we1_cnt = 0;
  int ack3_cnt = 0;
  logic [AW-1:0] we1_addr[$];
  int            we1_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Monitors pop the scoreboard whenever an ack is seen.
  always @(negedge clk) begin
    if (bus1.mem_we) begin
      we1_cnt++;
      we1_addr.push_back(bus1.mem_addr);
      we1_cyc.push_back(cyc);
    end
    if (bus1.ack != '0) begin
      if (sb1.size() == 0) begin
        chk("dut1 unexpected ack", 64'(bus1.ack), 64'd0);
      end else begin
        e1 = sb1.pop_front();
        chk("dut1 ack", 64'(bus1.ack), 64'(e1.ack));
        if (e1.rd) chk("dut1 rdata", 64'(bus1.rdata), 64'(e1.data));
      end
    end
  end

  always @(negedge clk) begin
    if (bus3.ack != '0) begin
      ack3_cnt++;
      if (sb3.size() == 0) begin
        chk("dut3 unexpected ack", 64'(bus3.ack), 64'd0);
      end else begin
        e3 = sb3.pop_front();
        chk("dut3 ack", 64'(bus3.ack), 64'(e3.ack));
        if (e3.rd) chk("dut3 rdata", 64'(bus3.rdata), 64'(e3.data));
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input int unsigned idx, input logic r, input logic we,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (sel == 1) begin
      rq1[2'(idx)] = r; wq1[2'(idx)] = we; a1[2'(idx)] = a; d1[2'(idx)] = d;
    end else begin
      rq3[2'(idx)] = r; wq3[2'(idx)] = we; a3[2'(idx)] = a; d3[2'(idx)] = d;
    end
  endtask

  task automatic wait_ack(input int sel, input int budget, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while ((((sel == 1) ? bus1.ack : bus3.ack) == '0) && (n < budget));
  endtask

  int n, base;

  initial begin
    for (int i = 0; i < int'(NR); i++) begin
      a1[i] = '0; d1[i] = '0; a3[i] = '0; d3[i] = '0;
    end
    #1;
    rst1_n = 1'b0;
    rst3_n = 1'b0;
    #1;
    chk("rst ack", 64'(bus1.ack), 64'd0);
    chk("rst rdata", 64'(bus1.rdata), 64'd0);
    chk("rst busy", 64'(bus1.busy), 64'd0);
    chk("rst last_grant", 64'(bus1.last_grant), 64'd2);
    chk("rst mem_addr", 64'(bus1.mem_addr), 64'd0);
    chk("rst mem_wdata", 64'(bus1.mem_wdata), 64'd0);
    chk("rst mem_we", 64'(bus1.mem_we), 64'd0);
    chk("rst3 last_grant", 64'(bus3.last_grant), 64'd2);
    step(); step();
    rst1_n = 1'b1;
    rst3_n = 1'b1;
    step();

    // Single write from the DMA slot.
    base = we1_cnt;
    drive(1, ReqDma, 1'b1, 1'b1, 16'h0010, 32'hDEADBEEF);
    sb1.push_back('{ack: 3'b001, rd: 1'b0, data: '0});
    step();
    chk("t1 mem_we", 64'(bus1.mem_we), 64'd1);
    chk("t1 mem_addr", 64'(bus1.mem_addr), 64'h0010);
    chk("t1 mem_wdata", 64'(bus1.mem_wdata), 64'hDEADBEEF);
    chk("t1 busy", 64'(bus1.busy), 64'd1);
    chk("t1 last_grant", 64'(bus1.last_grant), 64'd0);
    step();
    chk("t1 ack at cycle 2", 64'(bus1.ack), 64'b001);
    chk("t1 mem_we dropped", 64'(bus1.mem_we), 64'd0);
    drive(1, ReqDma, 1'b0, 1'b0, 16'h0, 32'h0);
    step(); step();
    chk("t1 one we pulse", 64'(we1_cnt - base), 64'd1);

    // Readback from the stack slot, latency 1.
    base = we1_cnt;
    drive(1, ReqStack, 1'b1, 1'b0, 16'h0010, 32'h0);
    sb1.push_back('{ack: 3'b010, rd: 1'b1, data: 32'hDEADBEEF});
    wait_ack(1, 10, n);
    chk("t2 read ack cycle", 64'(n), 64'd3);
    chk("t2 rdata", 64'(bus1.rdata), 64'hDEADBEEF);
    drive(1, ReqStack, 1'b0, 1'b0, 16'h0, 32'h0);
    step();
    chk("t2 no we on read", 64'(we1_cnt - base), 64'd0);
    chk("t2 last_grant", 64'(bus1.last_grant), 64'd1);
    chk("t2 rdata held", 64'(bus1.rdata), 64'hDEADBEEF);

    // Contention from reset: all three hold requests, expect 0,1,2,0,1,2.
    rst1_n = 1'b0;
    #1;
    chk("t3 async reset last_grant", 64'(bus1.last_grant), 64'd2);
    step();
    rst1_n = 1'b1;
    we1_addr.delete();
    we1_cyc.delete();
    for (int i = 0; i < 3; i++) begin
      drive(1, i, 1'b1, 1'b1, 16'(16'h0100 + i), 32'(32'hC0DE0000 + i));
    end
    for (int k = 0; k < 6; k++) begin
      sb1.push_back('{ack: 3'(1 << (k % 3)), rd: 1'b0, data: '0});
    end
    for (int k = 0; k < 60 && sb1.size() != 0; k++) step();
    for (int i = 0; i < 3; i++) drive(1, i, 1'b0, 1'b0, 16'h0, 32'h0);
    chk("t3 drained", 64'(sb1.size()), 64'd0);
    step(); step(); step();
    chk("t3 grant count", 64'(we1_addr.size()), 64'd6);
    for (int k = 0; k < 6 && k < we1_addr.size(); k++) begin
      chk("t3 grant addr", 64'(we1_addr[k]), 64'(16'h0100 + (k % 3)));
    end
    chk("t3 last_grant", 64'(bus1.last_grant), 64'd2);

    // Requester 0 drops its read request right after grant.
    drive(1, ReqDma, 1'b1, 1'b0, 16'h0100, 32'h0);
    sb1.push_back('{ack: 3'b001, rd: 1'b1, data: 32'hC0DE0000});
    step();
    chk("t4 busy after grant", 64'(bus1.busy), 64'd1);
    drive(1, ReqDma, 1'b0, 1'b0, 16'h0, 32'h0);
    wait_ack(1, 10, n);
    chk("t4 ack still pulses", 64'(n), 64'd2);
    step(); step(); step(); step();
    chk("t4 no second grant", 64'(sb1.size()), 64'd0);
    chk("t4 busy idle", 64'(bus1.busy), 64'd0);
    chk("t4 last_grant", 64'(bus1.last_grant), 64'd0);

    // Back-to-back writes from requester 1.
    we1_addr.delete();
    we1_cyc.delete();
    drive(1, ReqStack, 1'b1, 1'b1, 16'hFFFF, 32'h1111FFFF);
    sb1.push_back('{ack: 3'b010, rd: 1'b0, data: '0});
    sb1.push_back('{ack: 3'b010, rd: 1'b0, data: '0});
    wait_ack(1, 10, n);
    chk("t5 first ack", 64'(n), 64'd2);
    drive(1, ReqStack, 1'b1, 1'b1, 16'h0000, 32'h22220000);
    wait_ack(1, 10, n);
    chk("t5 second ack", 64'(n), 64'd3);
    drive(1, ReqStack, 1'b0, 1'b0, 16'h0, 32'h0);
    step(); step();
    chk("t5 pulse count", 64'(we1_addr.size()), 64'd2);
    if (we1_addr.size() == 2) begin
      chk("t5 addr0", 64'(we1_addr[0]), 64'hFFFF);
      chk("t5 addr1", 64'(we1_addr[1]), 64'h0000);
      chk("t5 pulse spacing", 64'(we1_cyc[1] - we1_cyc[0]), 64'd3);
    end
    chk("t5 ram FFFF", 64'(ram1[16'hFFFF]), 64'h1111FFFF);
    chk("t5 ram 0000", 64'(ram1[16'h0000]), 64'h22220000);

    // Latency-3 instance: seed a word, then abort a read with reset during WAIT.
    drive(3, ReqStack, 1'b1, 1'b1, 16'h0030, 32'hA5A50030);
    sb3.push_back('{ack: 3'b010, rd: 1'b0, data: '0});
    wait_ack(3, 10, n);
    chk("t6 seed write ack", 64'(n), 64'd2);
    drive(3, ReqStack, 1'b0, 1'b0, 16'h0, 32'h0);
    step();
    base = ack3_cnt;
    drive(3, ReqDma, 1'b1, 1'b0, 16'h0030, 32'h0);
    step(); step(); step();
    chk("t6 busy in wait", 64'(bus3.busy), 64'd1);
    rst3_n = 1'b0;
    #1;
    chk("t6 rst ack", 64'(bus3.ack), 64'd0);
    chk("t6 rst busy", 64'(bus3.busy), 64'd0);
    chk("t6 rst mem_we", 64'(bus3.mem_we), 64'd0);
    chk("t6 rst last_grant", 64'(bus3.last_grant), 64'd2);
    drive(3, ReqDma, 1'b0, 1'b0, 16'h0, 32'h0);
    step(); step();
    rst3_n = 1'b1;
    for (int k = 0; k < 6; k++) step();
    chk("t6 no ack after abort", 64'(ack3_cnt - base), 64'd0);

    drive(3, ReqIfetch, 1'b1, 1'b0, 16'h0030, 32'h0);
    sb3.push_back('{ack: 3'b100, rd: 1'b1, data: 32'hA5A50030});
    step();
    chk("t6 ifetch granted", 64'(bus3.last_grant), 64'(ReqIfetch));
    wait_ack(3, 10, n);
    chk("t6 read latency 3", 64'(n), 64'd4);
    drive(3, ReqIfetch, 1'b0, 1'b0, 16'h0, 32'h0);
    step(); step();

    // After reset requester 0 outranks requester 2.
    rst3_n = 1'b0;
    step();
    rst3_n = 1'b1;
    drive(3, ReqDma, 1'b1, 1'b0, 16'h0030, 32'h0);
    drive(3, ReqIfetch, 1'b1, 1'b0, 16'h0030, 32'h0);
    sb3.push_back('{ack: 3'b001, rd: 1'b1, data: 32'hA5A50030});
    sb3.push_back('{ack: 3'b100, rd: 1'b1, data: 32'hA5A50030});
    for (int k = 0; k < 20 && sb3.size() > 1; k++) step();
    drive(3, ReqDma, 1'b0, 1'b0, 16'h0, 32'h0);
    for (int k = 0; k < 20 && sb3.size() > 0; k++) step();
    drive(3, ReqIfetch, 1'b0, 1'b0, 16'h0, 32'h0);
    step(); step(); step();

    chk("end sb1 empty", 64'(sb1.size()), 64'd0);
    chk("end sb3 empty", 64'(sb3.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
